// File: rtl/subtractor_if.sv
// Operand/result bundle for the registered subtractor; master drives operands,
// slave (the subtractor) returns the registered difference and flags.
interface subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  d, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output d, ovf, out_valid
  );
endinterface

// File: rtl/subtractor.sv
// Registered two's-complement subtractor d = a - b with signed-overflow flag.
// Define SUBTRACTOR_SAT_EN to clamp overflowing results instead of wrapping.
module subtractor #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  subtractor_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] raw;
  logic             carry;
  logic             ovf_d;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;
  logic             ovf_q;
  logic             valid_q;

  assign nb = ~bus.b;

  // Ripple chain of full adders, carry-in = 1; final carry-out is dropped.
  always_comb begin
    raw   = '0;
    carry = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      raw[i] = bus.a[i] ^ nb[i] ^ carry;
      carry  = (bus.a[i] & nb[i]) | (carry & (bus.a[i] ^ nb[i]));
    end
  end

  assign ovf_d = (bus.a[MSB] != bus.b[MSB]) && (raw[MSB] != bus.a[MSB]);

`ifdef SUBTRACTOR_SAT_EN
  always_comb begin
    d_d = raw;
    if (ovf_d) begin
      d_d      = bus.a[MSB] ? '0 : '1;
      d_d[MSB] = bus.a[MSB];
    end
  end
`else
  assign d_d = raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        d_q   <= d_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.d         = d_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: integer reference model, directed and random steps.
module tb_subtractor;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_d;
  logic [31:0] exp_ovf;

  subtractor_if #(.WIDTH(W)) bus ();

  subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: true signed difference, range check, then wrap or clamp.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [31:0] md, output logic [31:0] mo);
    int sa, sb, diff, lo, hi;
    sa   = int'($signed(av));
    sb   = int'($signed(bv));
    diff = sa - sb;
    hi   = (1 << (W - 1)) - 1;
    lo   = -(1 << (W - 1));
    mo   = (diff > hi || diff < lo) ? 32'd1 : 32'd0;
`ifdef SUBTRACTOR_SAT_EN
    if (diff > hi) diff = hi;
    if (diff < lo) diff = lo;
`endif
    md = 32'(diff) & ((32'd1 << W) - 32'd1);
  endtask

  task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
    if (v) model(av, bv, exp_d, exp_ovf);
    chk("out_valid", 32'(bus.out_valid), 32'(v));
    chk("d", 32'(bus.d), exp_d);
    chk("ovf", 32'(bus.ovf), exp_ovf);
  endtask

  initial begin
    logic [W-1:0] ovf_a [3];
    logic [W-1:0] ovf_b [3];
    logic [31:0]  ovf_exp [3];
    n_tests = 0;
    n_fail  = 0;
    exp_d   = '0;
    exp_ovf = '0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // Reset state before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic vectors from the plan, compared to constants
    step(1'b1, 4'b0000, 4'b0001);
    chk("c_0m1_d", 32'(bus.d), 32'hF);
    chk("c_0m1_ovf", 32'(bus.ovf), 32'd0);
    step(1'b1, 4'b0101, 4'b0101);
    chk("c_eq_d", 32'(bus.d), 32'h0);
    step(1'b1, 4'b0011, 4'b1110);
    chk("c_3m2_d", 32'(bus.d), 32'h5);

    ovf_a = '{4'b0111, 4'b1000, 4'b0000};
    ovf_b = '{4'b1111, 4'b0001, 4'b1000};
`ifdef SUBTRACTOR_SAT_EN
    ovf_exp = '{32'h7, 32'h8, 32'h7};
`else
    ovf_exp = '{32'h8, 32'h7, 32'h8};
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ovf_a[i], ovf_b[i]);
      chk("c_ovf_d", 32'(bus.d), ovf_exp[i]);
      chk("c_ovf_flag", 32'(bus.ovf), 32'd1);
    end

    // Handshake 1,0,1,1 with hold through the idle cycle
    step(1'b1, 4'b0110, 4'b0010);
    step(1'b0, 4'b1001, 4'b0111);
    step(1'b1, 4'b1000, 4'b0001);
    step(1'b1, 4'b0010, 4'b0110);

    // Exhaustive sweep with in_valid held high
    for (int ai = 0; ai < (1 << W); ai++)
      for (int bi = 0; bi < (1 << W); bi++)
        step(1'b1, W'(ai), W'(bi));

    // Random stream with random gaps
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));

    // Asynchronous reset mid-cycle with in_valid high: in-flight result discarded
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 4'b0111;
    bus.b        = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("arst_d", 32'(bus.d), 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    exp_d   = '0;
    exp_ovf = '0;
    @(posedge clk);
    #1;
    chk("arst_hold_d", 32'(bus.d), 32'd0);
    chk("arst_hold_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step(1'b1, 4'b0100, 4'b0001);
    chk("post_rst_d", 32'(bus.d), 32'h3);
    step(1'b0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/subtractor.md
# subtractor

Registered two's-complement subtractor computing d = a − b on WIDTH-bit signed operands, with a signed-overflow flag. A leaf arithmetic block for datapath use: operands are sampled on a valid strobe and the result is presented one clock later, alongside a matching valid flag.

## Interface
- WIDTH, default 4: operand and result width in bits (≥ 2).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b are sampled on this cycle.
- a  input  WIDTH  minuend, two's complement.
- b  input  WIDTH  subtrahend, two's complement.
- d  output  WIDTH  registered difference a − b.
- ovf  output  1  registered signed-overflow flag for d.
- out_valid  output  1  d and ovf hold a new result this cycle.

## Operation
- The difference is formed as a + ~b + 1, using a ripple chain of WIDTH full adders with carry-in = 1. The raw difference is the low WIDTH bits; the final carry-out is discarded.
- ovf = (a[MSB] ≠ b[MSB]) AND (raw[MSB] ≠ a[MSB]). This means the true signed result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Unsigned borrow is not an output. For example, 0000 − 0001 gives 1111 with ovf = 0.
- When in_valid = 1 at a rising edge:
  - d ← result (see Configuration).
  - ovf ← overflow.
  - out_valid ← 1.
- When in_valid = 0 at a rising edge:
  - d and ovf hold their previous values.
  - out_valid ← 0.
- There is no back-pressure. Every valid input produces exactly one result, one cycle later.
- a = b always yields d = 0, ovf = 0.
- Boundary cases:
  - a = min, b = 1: ovf = 1.
  - a = max, b = −1: ovf = 1.
  - a = 0, b = min: ovf = 1. The raw difference is min (wrap-around).

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on d/ovf after edge N, with out_valid high for the cycle following edge N.
- Throughput is one operation per clock. Back-to-back in_valid pulses produce back-to-back results.
- The outputs are driven directly from flops. There is no combinational path from inputs to outputs.
- Reset:
  - While rst = 1: d = 0, ovf = 0, out_valid = 0, taking effect immediately and independent of clk.
  - Reset asserted mid-operation discards the in-flight result.
  - On the first rising edge after rst deasserts, normal sampling resumes.

## Configuration
- Macro SUBTRACTOR_SAT_EN enables saturation.
- Defined (saturating):
  - If ovf = 1, d is clamped to the representable limit.
  - For positive overflow (a[MSB] = 0), d = 2^(WIDTH−1)−1, e.g. 0111.
  - For negative overflow (a[MSB] = 1), d = −2^(WIDTH−1), e.g. 1000.
  - ovf is still reported as 1.
  - Non-overflow results are unchanged.
- Undefined (default, wrapping): d is always the raw WIDTH-bit difference.

## Test plan
- Reset: assert rst asynchronously, mid-stream and with in_valid = 1 → d = 0000, ovf = 0, out_valid = 0 immediately. The first result after release is correct.
- Basic cases at WIDTH = 4, wrap build:
  - 0000 − 0001 → d = 1111, ovf = 0.
  - 0101 − 0101 → d = 0000, ovf = 0.
  - 0011 − 1110 → d = 0101, ovf = 0.
- Overflow, wrap build:
  - 0111 − 1111 → d = 1000, ovf = 1.
  - 1000 − 0001 → d = 0111, ovf = 1.
  - 0000 − 1000 → d = 1000, ovf = 1.
- Overflow, SUBTRACTOR_SAT_EN build: same three vectors → d = 0111, 1000, 0111 respectively, all with ovf = 1.
- Exhaustive sweep, both builds: all 256 (a, b) pairs with in_valid held high → each result matches a reference model one cycle later, with out_valid = 1 on every cycle after the first.
- Handshake: in_valid pattern 1,0,1,1 → out_valid 1,0,1,1 delayed one cycle. d and ovf hold their values through the idle cycle.
